e_input_conditioner: RTL and testbench

E_INPUT_CONDITIONER -- requirements
Module: e_input_conditioner

---
 rtl/e_input_conditioner.sv | 156 +++++++++++++++
 tb/tb_e_input_conditioner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/e_input_conditioner.sv
// Switch input conditioner: synchronizes RAW_IN, debounces it with a four-state
// run-length FSM and reports the accepted level, edge pulses and rejected glitches.
module e_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RAW_IN,
  output logic       E,
  output logic       E_RISE,
  output logic       E_FALL,
  output logic       STABLE,
  output logic [7:0] GLITCH_CNT
);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    RISE_PEND = 2'd1,
    HIGH      = 2'd2,
    FALL_PEND = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST     = 8'(DEBOUNCE_CYCLES - 1);
  localparam bit         DIRECT_ACCEPT = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   s;

  state_t     state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] glitch_reg, glitch_next;
  logic       glitch_inc;
  logic       e_reg, e_next;
  logic       rise_reg, rise_next;
  logic       fall_reg, fall_next;
  logic       stable_reg, stable_next;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = RAW_IN;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  // Only the last synchronizer stage is safe to use as a level.
  assign s = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg  <= LOW;
      cnt_reg    <= '0;
      glitch_reg <= '0;
      e_reg      <= 1'b0;
      rise_reg   <= 1'b0;
      fall_reg   <= 1'b0;
      stable_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      glitch_reg <= glitch_next;
      e_reg      <= e_next;
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      stable_reg <= stable_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    glitch_inc = 1'b0;

    case (state_reg)
      LOW: begin
        if (s) begin
          if (DIRECT_ACCEPT) begin
            state_next = HIGH;
            cnt_next   = '0;
          end else begin
            state_next = RISE_PEND;
            cnt_next   = 8'd1;
          end
        end
      end
      RISE_PEND: begin
        if (!s) begin
          state_next = LOW;
          cnt_next   = '0;
          glitch_inc = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      HIGH: begin
        if (!s) begin
          if (DIRECT_ACCEPT) begin
            state_next = LOW;
            cnt_next   = '0;
          end else begin
            state_next = FALL_PEND;
            cnt_next   = 8'd1;
          end
        end
      end
      FALL_PEND: begin
        if (s) begin
          state_next = HIGH;
          cnt_next   = '0;
          glitch_inc = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase

    // Saturate rather than wrap so a noisy switch never looks clean again.
    glitch_next = (glitch_inc && (glitch_reg != 8'hFF)) ? glitch_reg + 8'd1 : glitch_reg;

    // Pulses fire only on accepted changes, never on a pend aborting back home.
    rise_next   = (state_next == HIGH) && ((state_reg == LOW) || (state_reg == RISE_PEND));
    fall_next   = (state_next == LOW) && ((state_reg == HIGH) || (state_reg == FALL_PEND));
    e_next      = (state_next == HIGH) || (state_next == FALL_PEND);
    stable_next = (state_next == LOW) || (state_next == HIGH);
  end

  assign E          = e_reg;
  assign E_RISE     = rise_reg;
  assign E_FALL     = fall_reg;
  assign STABLE     = stable_reg;
  assign GLITCH_CNT = glitch_reg;

endmodule

// File: tb/tb_e_input_conditioner.sv
// Bench for e_input_conditioner: two instances (DEBOUNCE_CYCLES 4 and 1) share
// one stimulus and are checked every cycle against a run-length reference model.
module tb_e_input_conditioner;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RAW_IN = 1'b0;
  logic       e_o[2];
  logic       rise_o[2];
  logic       fall_o[2];
  logic       stable_o[2];
  logic [7:0] glitch_o[2];

  int total = 0;
  int bad   = 0;

  localparam int SYNC = 2;
  int deb_m[2] = '{4, 1};

  // Reference model state, expressed as "how many samples in a row disagree".
  bit e_m[2];
  bit rise_m[2];
  bit fall_m[2];
  int run_m[2];
  int glitch_m[2];
  bit syncq[$];
  bit s_m;

  bit e_prev[2];
  int edges_n[2];
  int pulses_n[2];
  bit count_en = 1'b0;

  always #5 CLK = ~CLK;

  e_input_conditioner #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) u_d4 (
    .CLK(CLK), .RST(RST), .RAW_IN(RAW_IN),
    .E(e_o[0]), .E_RISE(rise_o[0]), .E_FALL(fall_o[0]),
    .STABLE(stable_o[0]), .GLITCH_CNT(glitch_o[0])
  );

  e_input_conditioner #(.DEBOUNCE_CYCLES(1), .SYNC_STAGES(2)) u_d1 (
    .CLK(CLK), .RST(RST), .RAW_IN(RAW_IN),
    .E(e_o[1]), .E_RISE(rise_o[1]), .E_FALL(fall_o[1]),
    .STABLE(stable_o[1]), .GLITCH_CNT(glitch_o[1])
  );

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      syncq.delete();
      for (int k = 0; k < SYNC; k++) syncq.push_back(1'b0);
      for (int i = 0; i < 2; i++) begin
        e_m[i] = 1'b0; rise_m[i] = 1'b0; fall_m[i] = 1'b0;
        run_m[i] = 0; glitch_m[i] = 0;
      end
    end else begin
      s_m = syncq.pop_front();
      syncq.push_back(RAW_IN);
      for (int i = 0; i < 2; i++) begin
        rise_m[i] = 1'b0;
        fall_m[i] = 1'b0;
        if (s_m != e_m[i]) begin
          run_m[i]++;
          if (run_m[i] >= deb_m[i]) begin
            e_m[i]    = s_m;
            rise_m[i] = s_m;
            fall_m[i] = !s_m;
            run_m[i]  = 0;
          end
        end else begin
          if (run_m[i] > 0 && glitch_m[i] < 255) glitch_m[i]++;
          run_m[i] = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input int exp);
    total++;
    if (act !== 8'(exp)) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("d%0d_E", deb_m[i]), 8'(e_o[i]), int'(e_m[i]));
      chk($sformatf("d%0d_E_RISE", deb_m[i]), 8'(rise_o[i]), int'(rise_m[i]));
      chk($sformatf("d%0d_E_FALL", deb_m[i]), 8'(fall_o[i]), int'(fall_m[i]));
      chk($sformatf("d%0d_STABLE", deb_m[i]), 8'(stable_o[i]), (run_m[i] == 0) ? 1 : 0);
      chk($sformatf("d%0d_GLITCH_CNT", deb_m[i]), glitch_o[i], glitch_m[i]);
      if (count_en) begin
        if (e_o[i] !== e_prev[i]) edges_n[i]++;
        if (rise_o[i] === 1'b1) pulses_n[i]++;
        if (fall_o[i] === 1'b1) pulses_n[i]++;
      end
      e_prev[i] = e_o[i];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
      compare_all();
    end
  endtask

  initial begin
    int lvl;
    int len;

    tick(3);
    chk("rst_d4_E", 8'(e_o[0]), 0);
    chk("rst_d4_STABLE", 8'(stable_o[0]), 1);
    chk("rst_d4_GLITCH", glitch_o[0], 0);
    RST = 1'b0;

    // Rise accepted after edge 15 when RAW_IN goes high before edge 10.
    tick(9);
    RAW_IN = 1'b1;
    tick(5);
    chk("lat_d4_E_edge14", 8'(e_o[0]), 0);
    tick(1);
    chk("lat_d4_E_edge15", 8'(e_o[0]), 1);
    chk("lat_d4_RISE_edge15", 8'(rise_o[0]), 1);
    tick(1);
    chk("lat_d4_RISE_edge16", 8'(rise_o[0]), 0);
    chk("lat_d4_GLITCH", glitch_o[0], 0);

    // Two-cycle low dip from HIGH is rejected.
    RAW_IN = 1'b0;
    tick(2);
    RAW_IN = 1'b1;
    tick(1);
    chk("dip_d4_STABLE_e19", 8'(stable_o[0]), 0);
    chk("dip_d4_FALL_e19", 8'(fall_o[0]), 0);
    chk("dip_d1_E_e19", 8'(e_o[1]), 0);
    tick(1);
    chk("dip_d4_STABLE_e20", 8'(stable_o[0]), 0);
    chk("dip_d4_E_e20", 8'(e_o[0]), 1);
    chk("dip_d4_FALL_e20", 8'(fall_o[0]), 0);
    tick(1);
    chk("dip_d4_STABLE_e21", 8'(stable_o[0]), 1);
    chk("dip_d4_E_e21", 8'(e_o[0]), 1);
    chk("dip_d4_FALL_e21", 8'(fall_o[0]), 0);
    chk("dip_d4_GLITCH", glitch_o[0], 1);
    chk("dip_d1_E_e21", 8'(e_o[1]), 1);

    // Asynchronous reset in the middle of a rise pend (CNT=2).
    RAW_IN = 1'b0;
    tick(8);
    RAW_IN = 1'b1;
    tick(4);
    chk("pend_d4_STABLE", 8'(stable_o[0]), 0);
    chk("pend_d4_E", 8'(e_o[0]), 0);
    RST = 1'b1;
    #1;
    chk("arst_d4_E", 8'(e_o[0]), 0);
    chk("arst_d4_STABLE", 8'(stable_o[0]), 1);
    chk("arst_d4_GLITCH", glitch_o[0], 0);
    chk("arst_d1_E", 8'(e_o[1]), 0);
    tick(1);
    RST = 1'b0;
    tick(5);
    chk("post_d4_E_e5", 8'(e_o[0]), 0);
    chk("post_d4_RISE_e5", 8'(rise_o[0]), 0);
    tick(1);
    chk("post_d4_E_e6", 8'(e_o[0]), 1);
    chk("post_d4_RISE_e6", 8'(rise_o[0]), 1);

    // 300 single-cycle glitches saturate the counter.
    RAW_IN = 1'b0;
    tick(8);
    for (int g = 0; g < 300; g++) begin
      RAW_IN = 1'b1;
      tick(1);
      RAW_IN = 1'b0;
      tick(1);
    end
    tick(6);
    chk("sat_d4_GLITCH", glitch_o[0], 255);
    chk("sat_d4_E", 8'(e_o[0]), 0);
    for (int g = 0; g < 2; g++) begin
      RAW_IN = 1'b1;
      tick(1);
      RAW_IN = 1'b0;
      tick(1);
    end
    tick(6);
    chk("sat_d4_GLITCH_hold", glitch_o[0], 255);
    chk("sat_d1_GLITCH", glitch_o[1], 0);

    // DEBOUNCE_CYCLES=1: a one-cycle pulse passes straight through.
    RAW_IN = 1'b1;
    tick(1);
    RAW_IN = 1'b0;
    tick(2);
    chk("p1_d1_E_a", 8'(e_o[1]), 1);
    chk("p1_d1_RISE_a", 8'(rise_o[1]), 1);
    chk("p1_d1_FALL_a", 8'(fall_o[1]), 0);
    tick(1);
    chk("p1_d1_E_b", 8'(e_o[1]), 0);
    chk("p1_d1_RISE_b", 8'(rise_o[1]), 0);
    chk("p1_d1_FALL_b", 8'(fall_o[1]), 1);
    tick(1);
    chk("p1_d1_FALL_c", 8'(fall_o[1]), 0);

    // Random bounce: pulse count must equal the number of E edges.
    tick(8);
    for (int i = 0; i < 2; i++) begin
      edges_n[i] = 0;
      pulses_n[i] = 0;
    end
    count_en = 1'b1;
    lvl = 0;
    for (int r = 0; r < 150; r++) begin
      lvl = 1 - lvl;
      RAW_IN = lvl[0];
      len = $urandom_range(1, 8);
      tick(len);
    end
    tick(12);
    count_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rnd_d%0d_pulses_vs_edges", deb_m[i]), 8'(pulses_n[i]), edges_n[i] % 256);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
